// File: rtl/load_store_unit_if.sv
// Request, load-response and data-memory signals of the load/store unit.
// The LSU connects through the slave modport; the requester and memory use master.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_valid;
    logic                  acc_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, ld_data, ld_valid, acc_err, mem_addr, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, ld_data, ld_valid, acc_err, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-addressed memory (4-byte words).
// Sub-word stores are done as a read in the accept cycle and a merged write in MERGE.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 100
) (
    input logic              CLK,
    input logic              RST,
    load_store_unit_if.slave bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_t;

    localparam logic [1:0]            SZ_BYTE     = 2'b00;
    localparam logic [1:0]            SZ_HALF     = 2'b01;
    localparam logic [1:0]            SZ_WORD     = 2'b10;
    localparam logic [1:0]            SZ_ILLEGAL  = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [1:0]            r_lane;
    logic                  r_half;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_ld_data;
    logic                  r_ld_valid;
    logic                  r_acc_err;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_ok;
    logic                  w_word_store;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ld_ext;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_idx    = bus.req_addr >> 2;
    assign w_lane   = bus.req_addr[1:0];
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = bus.req_valid && w_idle;

    assign w_err = (bus.req_size == SZ_ILLEGAL)
                || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                || ((bus.req_size == SZ_WORD) && (w_lane != 2'b00))
                || (w_idx >= DEPTH_LIMIT);

    assign w_ok         = w_accept && !w_err;
    assign w_word_store = w_ok && bus.req_write && (bus.req_size == SZ_WORD);

    // Little-endian lane pick from the word read this cycle.
    assign w_byte = bus.mem_rd[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_ld_ext = bus.mem_rd;
        case (bus.req_size)
            SZ_BYTE: w_ld_ext = {{(DATA_WIDTH-8){bus.req_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_ld_ext = {{(DATA_WIDTH-16){bus.req_signed & w_half[15]}}, w_half};
            default: w_ld_ext = bus.mem_rd;
        endcase
    end

    // Replace only the target lane(s) of the word captured in the accept cycle.
    always_comb begin
        w_merged = r_word;
        if (r_half) begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end else begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    assign bus.req_ready = w_idle;
    assign bus.mem_we    = (r_state == S_MERGE) || w_word_store;
    assign bus.mem_addr  = (r_state == S_MERGE) ? r_idx : w_idx;
    assign bus.mem_wd    = (r_state == S_MERGE) ? w_merged : bus.req_wdata;
    assign bus.ld_data   = r_ld_data;
    assign bus.ld_valid  = r_ld_valid;
    assign bus.acc_err   = r_acc_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the store latches are ordinary flops, not a memory array, so they reset too;
            // an async reset in MERGE therefore drops mem_we at once and discards the store.
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_lane     <= '0;
            r_half     <= 1'b0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_ld_data  <= '0;
            r_ld_valid <= 1'b0;
            r_acc_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates land together at the edge.
            r_ld_valid <= 1'b0;
            r_acc_err  <= w_accept && w_err;
            case (r_state)
                S_IDLE: begin
                    if (w_ok) begin
                        if (!bus.req_write) begin
                            r_ld_data  <= w_ld_ext;
                            r_ld_valid <= 1'b1;
                        end else if (bus.req_size != SZ_WORD) begin
                            r_idx   <= w_idx;
                            r_lane  <= w_lane;
                            r_half  <= (bus.req_size == SZ_HALF);
                            r_wdata <= bus.req_wdata;
                            r_word  <= bus.mem_rd;
                            r_state <= S_MERGE;
                        end
                    end
                end
                S_MERGE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 100-word memory model, a response
// scoreboard queue and one task per feature.
module tb_load_store_unit;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 100;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic mem_clear = 1'b1;
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] last_ld = '0;
    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    assign bus.mem_rd = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[6:0]] : 32'h0;

    always @(posedge CLK) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.mem_we && (bus.mem_addr < DEPTH)) begin
            mem[bus.mem_addr[6:0]] <= bus.mem_wd;
        end
    end

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic acc_we, output logic [31:0] acc_addr,
                             output logic [31:0] acc_wd);
        int guard;
        guard = 0;
        @(negedge CLK);
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        while (bus.req_ready !== 1'b1 && guard < 8) begin
            @(negedge CLK);
            guard++;
        end
        n_total++;
        if (guard >= 8) $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, guard);
        else n_pass++;
        #1;
        acc_we   = bus.mem_we;
        acc_addr = bus.mem_addr;
        acc_wd   = bus.mem_wd;
        @(posedge CLK);
    endtask

    task automatic check_resp(input string name);
        exp_t e;
        int   lat;
        logic ok;
        e   = sb.pop_front();
        lat = 1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        while (bus.ld_valid !== 1'b1 && bus.acc_err !== 1'b1 && lat < 4) begin
            @(negedge CLK);
            lat++;
        end
        if (e.is_err)
            ok = (lat == 1) && (bus.acc_err === 1'b1) && (bus.ld_valid === 1'b0) && (bus.ld_data === last_ld);
        else
            ok = (lat == 1) && (bus.ld_valid === 1'b1) && (bus.acc_err === 1'b0) && (bus.ld_data === e.data);
        n_total++;
        if (!ok)
            $display("FAIL %s: lat=%0d ld_valid=%b acc_err=%b ld_data=%h, required lat=1 %s ld_data=%h",
                     name, lat, bus.ld_valid, bus.acc_err, bus.ld_data,
                     e.is_err ? "acc_err" : "ld_valid", e.is_err ? last_ld : e.data);
        else n_pass++;
        if (!e.is_err) last_ld = e.data;
        @(negedge CLK);
        n_total++;
        if (bus.ld_valid !== 1'b0 || bus.acc_err !== 1'b0)
            $display("FAIL %s_pulse: ld_valid=%b acc_err=%b one cycle later, required 0 0", name, bus.ld_valid, bus.acc_err);
        else n_pass++;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic        we;
        logic        exp_we;
        logic [31:0] a;
        logic [31:0] wd;
        drive_req(v.wr, v.sz, v.sgn, v.addr, v.wd, we, a, wd);
        exp_we = v.wr && !v.err && (v.sz == 2'b10);
        n_total++;
        if (we !== exp_we || (exp_we && (a !== (v.addr >> 2) || wd !== v.wd)))
            $display("FAIL %s_accept: mem_we=%b mem_addr=%h mem_wd=%h, required mem_we=%b mem_addr=%h mem_wd=%h",
                     name, we, a, wd, exp_we, v.addr >> 2, v.wd);
        else n_pass++;
        if (v.err || !v.wr) begin
            sb.push_back('{v.err, v.exp});
            check_resp(name);
        end else begin
            @(negedge CLK);
            bus.req_valid = 1'b0;
            n_total++;
            if (bus.ld_valid !== 1'b0 || bus.acc_err !== 1'b0)
                $display("FAIL %s_noresp: ld_valid=%b acc_err=%b after store, required 0 0", name, bus.ld_valid, bus.acc_err);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = '0;
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_total++;
        if ({bus.req_ready, bus.mem_we, bus.ld_valid, bus.acc_err, bus.ld_data} !== {4'b1000, 32'h0})
            $display("FAIL reset_state: ready/we/ld_valid/acc_err=%b%b%b%b ld_data=%h, required 1000 00000000",
                     bus.req_ready, bus.mem_we, bus.ld_valid, bus.acc_err, bus.ld_data);
        else n_pass++;
        mem_clear = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        n_total++;
        if ({bus.req_ready, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h8})
            $display("FAIL idle_outputs: ready=%b mem_we=%b mem_addr=%h, required 1 0 00000008",
                     bus.req_ready, bus.mem_we, bus.mem_addr);
        else n_pass++;
    endtask

    task automatic test_word();
        run_vec('{1'b1, 2'b10, 1'b0, 32'd4, 32'h11223344, 1'b0, 32'h0}, "sw_addr4");
        run_vec('{1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 1'b0, 32'h11223344}, "lw_addr4");
    endtask

    task automatic test_sub_store();
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        drive_req(1'b1, 2'b00, 1'b0, 32'd5, 32'h000000AB, we, a, wd);
        n_total++;
        if (we !== 1'b0) $display("FAIL sb_accept_we: mem_we=%b, required 0", we);
        else n_pass++;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h40;
        #1;
        n_total++;
        if ({bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wd} !== {2'b01, 32'h1, 32'h1122AB44})
            $display("FAIL sb_merge: ready=%b mem_we=%b mem_addr=%h mem_wd=%h, required 0 1 00000001 1122ab44",
                     bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wd);
        else n_pass++;
        @(negedge CLK);
        n_total++;
        if ({bus.req_ready, bus.mem_we, mem[1]} !== {2'b10, 32'h1122AB44})
            $display("FAIL sb_after: ready=%b mem_we=%b mem[1]=%h, required 1 0 1122ab44",
                     bus.req_ready, bus.mem_we, mem[1]);
        else n_pass++;
        run_vec('{1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 1'b0, 32'h1122AB44}, "lw_after_sb");
    endtask

    task automatic test_loads();
        vec_t v [0:10];
        run_vec('{1'b1, 2'b10, 1'b0, 32'd8,  32'h7F800180, 1'b0, 32'h0}, "sw_addr8");
        run_vec('{1'b1, 2'b10, 1'b0, 32'd12, 32'h80010000, 1'b0, 32'h0}, "sw_addr12");
        v = '{'{1'b0, 2'b00, 1'b1, 32'd8,  32'h0, 1'b0, 32'hFFFFFF80},
              '{1'b0, 2'b00, 1'b0, 32'd8,  32'h0, 1'b0, 32'h00000080},
              '{1'b0, 2'b00, 1'b1, 32'd9,  32'h0, 1'b0, 32'h00000001},
              '{1'b0, 2'b00, 1'b1, 32'd10, 32'h0, 1'b0, 32'hFFFFFF80},
              '{1'b0, 2'b00, 1'b1, 32'd11, 32'h0, 1'b0, 32'h0000007F},
              '{1'b0, 2'b01, 1'b1, 32'd14, 32'h0, 1'b0, 32'hFFFF8001},
              '{1'b0, 2'b01, 1'b0, 32'd14, 32'h0, 1'b0, 32'h00008001},
              '{1'b0, 2'b01, 1'b1, 32'd12, 32'h0, 1'b0, 32'h00000000},
              '{1'b0, 2'b01, 1'b1, 32'd8,  32'h0, 1'b0, 32'h00000180},
              '{1'b0, 2'b01, 1'b1, 32'd10, 32'h0, 1'b0, 32'h00007F80},
              '{1'b0, 2'b10, 1'b1, 32'd8,  32'h0, 1'b0, 32'h7F800180}};
        for (int i = 0; i < 11; i++) run_vec(v[i], $sformatf("load_%0d", i));
        repeat (2) @(negedge CLK);
        n_total++;
        if (bus.ld_data !== 32'h7F800180) $display("FAIL ld_data_hold: ld_data=%h, required 7f800180", bus.ld_data);
        else n_pass++;
    endtask

    task automatic test_errors();
        vec_t v [0:7];
        v = '{'{1'b0, 2'b01, 1'b1, 32'd3,   32'h0,      1'b1, 32'h0},
              '{1'b0, 2'b10, 1'b0, 32'd400, 32'h0,      1'b1, 32'h0},
              '{1'b0, 2'b10, 1'b0, 32'd6,   32'h0,      1'b1, 32'h0},
              '{1'b0, 2'b11, 1'b0, 32'd0,   32'h0,      1'b1, 32'h0},
              '{1'b1, 2'b10, 1'b0, 32'd400, 32'hDEADBEEF, 1'b1, 32'h0},
              '{1'b1, 2'b01, 1'b0, 32'd1,   32'h0000BEEF, 1'b1, 32'h0},
              '{1'b1, 2'b10, 1'b0, 32'd396, 32'h99999999, 1'b0, 32'h0},
              '{1'b0, 2'b10, 1'b0, 32'd396, 32'h0,      1'b0, 32'h99999999}};
        for (int i = 0; i < 8; i++) run_vec(v[i], $sformatf("err_%0d", i));
        n_total++;
        if (mem[0] !== 32'h0) $display("FAIL err_mem_untouched: mem[0]=%h, required 00000000", mem[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        drive_req(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000BEEF, we, a, wd);
        @(negedge CLK);
        bus.req_write = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'd4;
        bus.req_valid = 1'b1;
        #1;
        n_total++;
        if ({bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wd} !== {2'b01, 32'h1, 32'hBEEFAB44})
            $display("FAIL sh_merge_held: ready=%b mem_we=%b mem_addr=%h mem_wd=%h, required 0 1 00000001 beefab44",
                     bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wd);
        else n_pass++;
        run_vec('{1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 1'b0, 32'hBEEFAB44}, "lw_after_sh");
    endtask

    task automatic test_reset_merge();
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        run_vec('{1'b1, 2'b10, 1'b0, 32'd16, 32'hCAFEF00D, 1'b0, 32'h0}, "sw_addr16");
        drive_req(1'b1, 2'b00, 1'b0, 32'd17, 32'h00000055, we, a, wd);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        #1;
        n_total++;
        if (bus.mem_we !== 1'b1) $display("FAIL merge_entered: mem_we=%b, required 1", bus.mem_we);
        else n_pass++;
        RST = 1'b0;
        #1;
        n_total++;
        if ({bus.mem_we, bus.req_ready, bus.ld_valid, bus.ld_data} !== {3'b010, 32'h0})
            $display("FAIL reset_in_merge: mem_we=%b ready=%b ld_valid=%b ld_data=%h, required 0 1 0 00000000",
                     bus.mem_we, bus.req_ready, bus.ld_valid, bus.ld_data);
        else n_pass++;
        last_ld = '0;
        @(negedge CLK);
        RST = 1'b1;
        n_total++;
        if (mem[4] !== 32'hCAFEF00D) $display("FAIL reset_discard: mem[4]=%h, required cafef00d", mem[4]);
        else n_pass++;
        run_vec('{1'b0, 2'b10, 1'b0, 32'd16, 32'h0, 1'b0, 32'hCAFEF00D}, "lw_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_sub_store();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_merge();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
